// File: rtl/regfile_mp.sv
// regfile_mp: NREGS x WIDTH register file with two combinational read ports,
// one write port with same-cycle write-through bypass, and a per-register
// busy bit used to reserve a destination register ahead of its write.
module regfile_mp #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [AW-1:0]            writenum,
    input  logic                     write,
    input  logic [AW-1:0]            readnum_a,
    input  logic [AW-1:0]            readnum_b,
    output logic [WIDTH-1:0]         data_out_a,
    output logic [WIDTH-1:0]         data_out_b,
    output logic                     busy_a,
    output logic                     busy_b,
    input  logic                     reserve,
    input  logic [AW-1:0]            reservenum,
    output logic [NREGS-1:0]         busy_vec,
    output logic [WIDTH*NREGS-1:0]   regs_flat
);

    // Register contents and busy bits.
    logic [WIDTH-1:0] r_q [NREGS];
    logic [NREGS-1:0] b_q;
    logic [NREGS-1:0] b_d;

    // Per-register busy next state: a reservation wins over a same-cycle
    // write so an outstanding newer reservation (WAW) is not lost.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            always_comb begin
                b_d[gi] = b_q[gi];
                if (reserve && (reservenum == AW'(gi))) begin
                    b_d[gi] = 1'b1;
                end else if (write && (writenum == AW'(gi))) begin
                    b_d[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Register storage: reset clears everything, otherwise one indexed write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_q[i] <= '0;
            end
        end else if (write) begin
            r_q[writenum] <= data_in;
        end
    end

    // Busy flops: reset dominates reserve and write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q <= '0;
        end else begin
            b_q <= b_d;
        end
    end

    // Bypass and reservation compares for each read port.
    logic wr_hit_a, wr_hit_b;
    logic rs_hit_a, rs_hit_b;

    // Read port A: index mux with write-through bypass; a register being
    // written reads not-busy unless it is re-reserved in the same cycle.
    always_comb begin
        wr_hit_a   = write && (writenum == readnum_a);
        rs_hit_a   = reserve && (reservenum == readnum_a);
        data_out_a = wr_hit_a ? data_in : r_q[readnum_a];
        busy_a     = b_q[readnum_a] & ~(wr_hit_a & ~rs_hit_a);
    end

    // Read port B: identical structure to port A.
    always_comb begin
        wr_hit_b   = write && (writenum == readnum_b);
        rs_hit_b   = reserve && (reservenum == readnum_b);
        data_out_b = wr_hit_b ? data_in : r_q[readnum_b];
        busy_b     = b_q[readnum_b] & ~(wr_hit_b & ~rs_hit_b);
    end

    // Debug views of raw state, no bypass.
    assign busy_vec = b_q;

    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_flat
            assign regs_flat[gi*WIDTH +: WIDTH] = r_q[gi];
        end
    endgenerate

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the datapath, succeeding the fixed 8×16 single-read-port file. It provides NREGS registers of WIDTH bits with two independent combinational read ports, one write port with same-cycle write-through bypass, and a per-register busy (scoreboard) bit for reserving a destination register ahead of its write. Synchronous reset clears all registers and busy bits. The block sits between the instruction decoder/controller FSM and the ALU operand muxes.

## Interface
Parameters:
- WIDTH, 16, register data width in bits
- NREGS, 8, number of registers; must be a power of two, ≥2
- AW, 3, index width; must equal log2(NREGS)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, synchronous, active-low
- data_in  input  WIDTH  write data
- writenum  input  AW  write index
- write  input  1  write enable
- readnum_a  input  AW  read port A index
- readnum_b  input  AW  read port B index
- data_out_a  output  WIDTH  read port A data (combinational)
- data_out_b  output  WIDTH  read port B data (combinational)
- busy_a  output  1  register at readnum_a has a pending reservation (combinational)
- busy_b  output  1  register at readnum_b has a pending reservation (combinational)
- reserve  input  1  mark register reservenum busy
- reservenum  input  AW  index to reserve
- busy_vec  output  NREGS  registered busy bits, bit i = register i
- regs_flat  output  WIDTH*NREGS  all register contents for debug, register i at bits [i*WIDTH +: WIDTH]

## Operation
- Storage: NREGS × WIDTH flops `r[i]`. Busy flops `b[i]`.
- Write: on a rising edge with rst_n=1 and write=1, `r[writenum] <= data_in`. No other register changes.
- Read, per port p in {a, b}:
  - If write=1 and writenum==readnum_p, data_out_p = data_in (bypass).
  - Otherwise data_out_p = r[readnum_p].
  - Both ports may address the same register or the write index at the same time, with no restriction.
- Busy update on a rising edge with rst_n=1, per register i:
  - If reserve=1 and reservenum==i: `b[i] <= 1`. Reserve takes priority over a same-cycle write to the same index. That write still stores data; this is the WAW case where a newer reservation is outstanding.
  - Else if write=1 and writenum==i: `b[i] <= 0`.
  - Else `b[i]` holds.
- A reservation to a register that is already busy is legal. The bit stays 1 and a single write clears it.
- Busy read, per port p: busy_p = b[readnum_p] & ~(write & writenum==readnum_p & ~(reserve & reservenum==readnum_p)). A register being written this cycle reads not-busy, so it pairs correctly with the bypassed data.
- busy_vec = b, with no bypass. regs_flat = r, with no bypass.
- Reset: when rst_n=0 at a rising edge, all `r[i] <= 0` and all `b[i] <= 0`. Reset dominates write and reserve in that cycle.
- All index inputs are in range by construction (AW = log2(NREGS)); no out-of-range handling is needed.

## Timing
- Write latency: the value appears on data_out_p in the same cycle through the bypass, and on regs_flat one cycle later.
- Reserve latency: busy_vec bit is set one cycle after reserve is asserted. busy_p reflects the new reservation from the next cycle onward.
- Read ports are purely combinational from readnum_p, write, writenum and data_in. The read path is index mux plus bypass compare, with no flop in it.
- Reset values after the first rst_n=0 edge: regs_flat=0, busy_vec=0, data_out_a = data_out_b = 0 (when not bypassing), busy_a = busy_b = 0.
- Reset asserted mid-sequence, with reserve or write active in the same cycle: the next cycle shows all-zero state. Inputs from that cycle are lost.
- Throughput: one write and one reserve accepted every cycle, with no stall.

## Test plan
- Reset clear: write distinct values to all registers, then hold rst_n=0 for one edge with write=1 → regs_flat=0 and busy_vec=0 on the next cycle.
- Basic write/dual read: write 16'h1234 to R3 and 16'hBEEF to R5; read A=3, B=5 → data_out_a=16'h1234, data_out_b=16'hBEEF. Read A=B=3 → both 16'h1234.
- Bypass: R2=16'h0001. Same cycle write=1, writenum=2, data_in=16'hA5A5, readnum_a=2 → data_out_a=16'hA5A5 that cycle, and R2=16'hA5A5 afterwards.
- Scoreboard: reserve R6 → busy_vec=8'h40 next cycle and busy_a=1 with readnum_a=6. Write R6=16'h00FF → busy_a=0 in the write cycle, then busy_vec=0.
- Reserve/write collision: with R4 busy, assert reserve=1 on R4 and write=1 on R4 with 16'h7777 in the same cycle → R4=16'h7777, busy_vec[4] stays 1. Double reserve followed by one write → busy_vec[4]=0.
- Parameter sweep: WIDTH=32, NREGS=16, AW=4. Write index 15 with 32'hDEADBEEF → regs_flat[511:480]=32'hDEADBEEF. Repeat the scoreboard test on index 15.
